// File: rtl/se_sram_srw_master.sv
// Request/response initiator for a single-port synchronous SRAM.
// Reads come back in order through a 2-entry response buffer. Writes return no response.
module se_sram_srw_master #(
  parameter int address_width = 16,
  parameter int data_width    = 16
) (
  input  logic                     sram_clock,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_read_not_write,
  input  logic [address_width-1:0] req_address,
  input  logic [data_width-1:0]    req_write_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [data_width-1:0]    rsp_data,
  output logic                     idle,
  output logic                     sram_select,
  output logic                     sram_read_not_write,
  output logic                     sram_write_enable,
  output logic [address_width-1:0] sram_address,
  output logic [data_width-1:0]    sram_write_data,
  input  logic [data_width-1:0]    sram_data_in
);

  logic                  pending_reg;
  logic [1:0]            occupancy_reg;
  logic [data_width-1:0] buffer_reg [2];
  logic                  wr_ptr_reg;
  logic                  rd_ptr_reg;

  logic       pop;
  logic       push;
  logic       accept;
  logic       read_room;
  logic [2:0] committed;

  assign rsp_valid = (occupancy_reg != 2'd0);
  assign pop       = rsp_valid && rsp_ready;
  assign push      = pending_reg;

  // Reads already issued but not yet popped must leave room for this read's data.
  assign committed = {1'b0, occupancy_reg} + {2'b00, pending_reg} - {2'b00, pop};
  assign read_room = (committed < 3'd2);
  assign req_ready = reset_n && (!req_read_not_write || read_room);

  assign accept              = req_valid && req_ready;
  assign sram_select         = accept;
  assign sram_read_not_write = req_read_not_write;
  assign sram_write_enable   = accept && !req_read_not_write;
  assign sram_address        = req_address;
  assign sram_write_data     = req_write_data;

  assign rsp_data = buffer_reg[rd_ptr_reg];
  assign idle     = !pending_reg && (occupancy_reg == 2'd0);

  always_ff @(posedge sram_clock or negedge reset_n) begin
    if (!reset_n) begin
      pending_reg   <= 1'b0;
      occupancy_reg <= 2'd0;
      wr_ptr_reg    <= 1'b0;
      rd_ptr_reg    <= 1'b0;
      buffer_reg[0] <= '0;
      buffer_reg[1] <= '0;
    end else begin
      pending_reg <= accept && req_read_not_write;
      if (push) begin
        buffer_reg[wr_ptr_reg] <= sram_data_in;
        wr_ptr_reg             <= !wr_ptr_reg;
      end
      if (pop) begin
        rd_ptr_reg <= !rd_ptr_reg;
      end
      case ({push, pop})
        2'b10:   occupancy_reg <= occupancy_reg + 2'd1;
        2'b01:   occupancy_reg <= occupancy_reg - 2'd1;
        default: occupancy_reg <= occupancy_reg;
      endcase
    end
  end

  // The ready rule should make a push into a full buffer unreachable.
  assert property (@(posedge sram_clock) disable iff (!reset_n)
                   !(push && (occupancy_reg == 2'd2) && !pop));

endmodule
